registro_etapa_skid: RTL and testbench
======================================

// Module: registro_etapa_skid
// PURPOSE
//  Next-generation pipeline stage register (MEM/WB and peers) with parametrised payload.
//  Adds valid/ready flow control, a 1-entry skid buffer, flush, and bubble control gating.
//  Sits between two pipeline stages. Full throughput when downstream is ready; stalls lose nothing.
//  Also counts backpressure cycles for performance monitoring.
// PARAMETERS
//  DATA_W  32  width of each data word (alu_result / read_data)
//  NDATA   2   number of DATA_W words carried per entry
//  RD_W    5   destination register index width
//  CTRL_W  3   control bits (e.g. memtoreg, regwrite, jal); gated to 0 on bubbles
//  CNT_W   16  stall counter width (saturating)
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              synchronous reset, active-low
//  flush      in   1              discard all held entries
//  in_valid   in   1              upstream entry valid
//  in_ready   out  1              stage can accept this cycle (registered)
//  in_data    in   NDATA*DATA_W   payload words, word k at [k*DATA_W +: DATA_W]
//  in_rd      in   RD_W           destination register
//  in_ctrl    in   CTRL_W         control bits
//  out_valid  out  1              output entry valid
//  out_ready  in   1              downstream accepts
//  out_data   out  NDATA*DATA_W   held payload
//  out_rd     out  RD_W           held destination register
//  out_ctrl   out  CTRL_W         held control bits; 0 whenever out_valid=0
//  stall_cnt  out  CNT_W          cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  Storage: main register M (drives outputs) and skid register S.
//  State machine: EMPTY (M,S empty), ONE (M full), TWO (M,S full).
//  Events: acc = in_valid & in_ready; drn = out_valid & out_ready.
//  EMPTY: acc -> ONE, M<=in.
//  ONE:
//   - acc & drn -> ONE, M<=in.
//   - acc & !drn -> TWO, S<=in.
//   - !acc & drn -> EMPTY.
//   - otherwise hold.
//  TWO: in_ready=0. drn -> ONE, M<=S. Otherwise hold.
//  in_ready is a register. It is 1 in EMPTY/ONE and 0 in TWO, computed for the next state.
//  Latency: an entry accepted at edge N is visible on outputs after edge N (1 cycle) if M was empty or drained.
//  Ordering strictly FIFO. No entry is duplicated or lost except by flush/reset.
//  Held outputs are stable while out_valid=1 and out_ready=0.
//  Flush (priority over all events): next state EMPTY, in_ready<=1.
//   - in_valid in the flush cycle is dropped.
//   - out_valid=0 and out_ctrl=0 from the next cycle.
//   - Data/rd are don't-care after flush.
//  Bubble gating: out_ctrl = M.ctrl when out_valid=1, else all-zero. No spurious regwrite.
//  stall_cnt: +1 each cycle with out_valid & !out_ready. Saturates at 2^CNT_W-1. Cleared only by reset, not by flush.
//  Reset (rst_n=0 at an edge):
//   - state EMPTY, in_ready=1, out_valid=0.
//   - out_data=0, out_rd=0, out_ctrl=0, stall_cnt=0. S cleared.
//   - Reset mid-operation discards both entries.
// TESTING
//  1. Streaming: in_valid=1 and out_ready=1 for 8 cycles, data 1..8 -> out_valid from cycle 2, data 1..8 in order, in_ready stays 1.
//  2. Skid: send A,B while out_ready=0 -> in_ready=0 after B. C held upstream. out_ready=1 -> A, B, C out in order; stall_cnt counts the stalled cycles exactly.
//  3. Flush in TWO with in_valid=1 (D) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, D never appears.
//  4. Bubble gating: in_ctrl=3'b111 with in_valid=0 -> out_ctrl stays 3'b000.
//  5. Reset mid-stall (TWO, stall_cnt=5) -> all outputs 0, in_ready=1, stall_cnt=0. First post-reset entry has 1-cycle latency.
//  6. Saturation: CNT_W=4, hold stall 20 cycles -> stall_cnt=15 and stays 15.

Source files
------------

// File: rtl/registro_etapa_skid.sv
// registro_etapa_skid: pipeline stage register with valid/ready handshake,
// a one-entry skid buffer, flush, bubble gating of control bits and a
// saturating backpressure counter.
//
// Storage is a main register M (drives the outputs) and a skid register S.
// in_ready is a register: it is computed for the next state. Because of that,
// the upstream stage may present one more entry in the same cycle that M
// stalls, and S catches that entry.
module registro_etapa_skid #(
  parameter int DATA_W = 32,
  parameter int NDATA  = 2,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NDATA*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]         in_rd,
  input  logic [CTRL_W-1:0]       in_ctrl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NDATA*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]         out_rd,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int PAY_W = NDATA * DATA_W;

  // EMPTY: M and S empty; ONE: only M full; TWO: M and S full.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_p0;
  logic              vld_p0;
  logic [PAY_W-1:0]  m_data_p0;
  logic [RD_W-1:0]   m_rd_p0;
  logic [CTRL_W-1:0] m_ctrl_p0;
  logic [PAY_W-1:0]  s_data_p0;
  logic [RD_W-1:0]   s_rd_p0;
  logic [CTRL_W-1:0] s_ctrl_p0;
  logic [CNT_W-1:0]  stall_cnt_p0;

  logic acc;
  logic drn;
  logic stalled;

  // Saturating increment: the counter sticks at its all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + one;
  endfunction

  // Handshake events seen this cycle.
  assign acc     = in_valid & in_ready;
  assign drn     = vld_p0 & out_ready;
  assign stalled = vld_p0 & ~out_ready;

  // Entry state machine and payload registers; flush beats every event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0  <= ST_EMPTY;
      in_ready  <= 1'b1;
      vld_p0    <= 1'b0;
      m_data_p0 <= '0;
      m_rd_p0   <= '0;
      m_ctrl_p0 <= '0;
      s_data_p0 <= '0;
      s_rd_p0   <= '0;
      s_ctrl_p0 <= '0;
    end else if (flush) begin
      // Held payload is left in place; it is invisible once vld_p0 drops.
      state_p0 <= ST_EMPTY;
      in_ready <= 1'b1;
      vld_p0   <= 1'b0;
    end else begin
      case (state_p0)
        ST_EMPTY: begin
          in_ready <= 1'b1;
          if (acc) begin
            state_p0  <= ST_ONE;
            vld_p0    <= 1'b1;
            m_data_p0 <= in_data;
            m_rd_p0   <= in_rd;
            m_ctrl_p0 <= in_ctrl;
          end
        end
        ST_ONE: begin
          if (acc && drn) begin
            // Pass-through at full rate: M is replaced as it drains.
            m_data_p0 <= in_data;
            m_rd_p0   <= in_rd;
            m_ctrl_p0 <= in_ctrl;
          end else if (acc) begin
            // M is stalled; park the newcomer in S and stop upstream.
            state_p0  <= ST_TWO;
            in_ready  <= 1'b0;
            s_data_p0 <= in_data;
            s_rd_p0   <= in_rd;
            s_ctrl_p0 <= in_ctrl;
          end else if (drn) begin
            state_p0 <= ST_EMPTY;
            vld_p0   <= 1'b0;
          end
        end
        ST_TWO: begin
          if (drn) begin
            state_p0  <= ST_ONE;
            in_ready  <= 1'b1;
            m_data_p0 <= s_data_p0;
            m_rd_p0   <= s_rd_p0;
            m_ctrl_p0 <= s_ctrl_p0;
          end
        end
        default: begin
          state_p0 <= ST_EMPTY;
          in_ready <= 1'b1;
          vld_p0   <= 1'b0;
        end
      endcase
    end
  end

  // Backpressure counter: survives flush, only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_p0 <= '0;
    end else if (stalled) begin
      stall_cnt_p0 <= sat_inc(stall_cnt_p0);
    end
  end

  // Output stage: control bits are forced to zero on bubbles.
  assign out_valid = vld_p0;
  assign out_data  = m_data_p0;
  assign out_rd    = m_rd_p0;
  assign out_ctrl  = vld_p0 ? m_ctrl_p0 : '0;
  assign stall_cnt = stall_cnt_p0;

endmodule

// File: tb/tb_registro_etapa_skid.sv
// Testbench for registro_etapa_skid: a queue-based reference model of a
// two-deep FIFO with registered ready, checked every cycle on two instances
// (default counter width and a 4-bit counter for saturation).
module tb_registro_etapa_skid;

  localparam int DATA_W = 32;
  localparam int NDATA  = 2;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 3;
  localparam int PAY_W  = NDATA * DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              out_ready;
  logic [PAY_W-1:0]  in_data;
  logic [RD_W-1:0]   in_rd;
  logic [CTRL_W-1:0] in_ctrl;

  logic              a_in_ready, a_out_valid;
  logic [PAY_W-1:0]  a_out_data;
  logic [RD_W-1:0]   a_out_rd;
  logic [CTRL_W-1:0] a_out_ctrl;
  logic [15:0]       a_stall_cnt;

  logic              b_in_ready, b_out_valid;
  logic [PAY_W-1:0]  b_out_data;
  logic [RD_W-1:0]   b_out_rd;
  logic [CTRL_W-1:0] b_out_ctrl;
  logic [3:0]        b_stall_cnt;

  registro_etapa_skid #(.DATA_W(DATA_W), .NDATA(NDATA), .RD_W(RD_W),
                        .CTRL_W(CTRL_W), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_rd(a_out_rd), .out_ctrl(a_out_ctrl), .stall_cnt(a_stall_cnt)
  );

  registro_etapa_skid #(.DATA_W(DATA_W), .NDATA(NDATA), .RD_W(RD_W),
                        .CTRL_W(CTRL_W), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_rd(b_out_rd), .out_ctrl(b_out_ctrl), .stall_cnt(b_stall_cnt)
  );

  typedef struct packed {
    logic [PAY_W-1:0]  d;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] c;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  bit          m_rdy;
  int unsigned m_cnt;
  bit          m_zero;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int unsigned ca, cb;
    ca = (m_cnt > 65535) ? 65535 : m_cnt;
    cb = (m_cnt > 15) ? 15 : m_cnt;
    chk("in_ready", a_in_ready, m_rdy);
    chk("out_valid", a_out_valid, q.size() > 0);
    chk("b_in_ready", b_in_ready, m_rdy);
    chk("b_out_valid", b_out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_ctrl", a_out_ctrl, q[0].c);
      chk("out_data", a_out_data, q[0].d);
      chk("out_rd", a_out_rd, q[0].rd);
      chk("b_out_data", b_out_data, q[0].d);
    end else begin
      chk("out_ctrl_bubble", a_out_ctrl, 0);
      chk("b_out_ctrl_bubble", b_out_ctrl, 0);
      if (m_zero) begin
        chk("out_data_rst", a_out_data, 0);
        chk("out_rd_rst", a_out_rd, 0);
      end
    end
    chk("stall_cnt", a_stall_cnt, ca);
    chk("stall_cnt4", b_stall_cnt, cb);
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then check.
  task automatic step();
    bit   acc, drn;
    ent_t e;
    @(posedge clk);
    acc = in_valid && m_rdy;
    drn = (q.size() > 0) && out_ready;
    if (!rst_n) begin
      q.delete();
      m_rdy  = 1'b1;
      m_cnt  = 0;
      m_zero = 1'b1;
    end else begin
      if (q.size() > 0 && !out_ready) m_cnt++;
      if (flush) begin
        q.delete();
        m_rdy = 1'b1;
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) begin
          e.d  = in_data;
          e.rd = in_rd;
          e.c  = in_ctrl;
          q.push_back(e);
          m_zero = 1'b0;
        end
        m_rdy = (q.size() < 2);
      end
    end
    #1;
    check_all();
  endtask

  task automatic set_entry(input logic [PAY_W-1:0] d, input logic [RD_W-1:0] rd,
                           input logic [CTRL_W-1:0] c);
    in_data = d;
    in_rd   = rd;
    in_ctrl = c;
  endtask

  // Hold in_valid with the current payload until the model says it was taken.
  task automatic send();
    bit done;
    bit taken;
    done = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (!done) begin
        taken = m_rdy;
        step();
        if (taken) done = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk("send_accepted", done, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_rd = '0; in_ctrl = '0;
    m_rdy = 1'b1; m_cnt = 0; m_zero = 1'b1;
    step();
    step();
    rst_n = 1'b1;

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      set_entry(PAY_W'(i), RD_W'(i), CTRL_W'(i));
      step();
    end
    in_valid = 1'b0;
    step();

    // Skid: A and B under backpressure, C waits upstream
    out_ready = 1'b0;
    set_entry(64'hAAAA_0000_0000_000A, 5'd10, 3'b101); send();
    set_entry(64'hBBBB_0000_0000_000B, 5'd11, 3'b011); send();
    chk("skid_in_ready", a_in_ready, 1'b0);
    set_entry(64'hCCCC_0000_0000_000C, 5'd12, 3'b110);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b1;
    send();
    for (int i = 0; i < 3; i++) step();

    // Flush while full, with D offered in the flush cycle
    out_ready = 1'b0;
    set_entry(64'h1111_2222_3333_4444, 5'd1, 3'b111); send();
    set_entry(64'h5555_6666_7777_8888, 5'd2, 3'b111); send();
    set_entry(64'hDDDD_DDDD_DDDD_DDDD, 5'd13, 3'b111);
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    chk("flush_ctrl", a_out_ctrl, 3'b000);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Bubble gating: control bits on idle input, and after a drained entry
    in_ctrl = 3'b111;
    for (int i = 0; i < 3; i++) step();
    set_entry(64'h0123_4567_89AB_CDEF, 5'd31, 3'b111); send();
    in_ctrl = 3'b111;
    for (int i = 0; i < 3; i++) step();

    // Reset in the middle of a stall
    do_reset();
    out_ready = 1'b0;
    set_entry(64'h00A0, 5'd3, 3'b001); send();
    set_entry(64'h00B0, 5'd4, 3'b010); send();
    for (int i = 0; i < 4; i++) step();
    chk("t5_stall_cnt", a_stall_cnt, 16'd5);
    chk("t5_in_ready", a_in_ready, 1'b0);
    do_reset();
    chk("t5_rst_data", a_out_data, 0);
    chk("t5_rst_cnt", a_stall_cnt, 0);
    out_ready = 1'b1;
    set_entry(64'h00E0, 5'd7, 3'b100); send();

    // Saturation of the narrow counter
    do_reset();
    out_ready = 1'b0;
    set_entry(64'h0F0F, 5'd9, 3'b010); send();
    for (int i = 0; i < 20; i++) step();
    chk("sat4_cnt", b_stall_cnt, 4'd15);
    chk("sat16_cnt", a_stall_cnt, 16'd20);
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b1;
    step();

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(63) != 0);
      flush     = ($urandom_range(15) == 0);
      in_valid  = $urandom_range(1);
      out_ready = ($urandom_range(9) < 6);
      in_data   = {$urandom(), $urandom()};
      in_rd     = RD_W'($urandom());
      in_ctrl   = CTRL_W'($urandom());
      step();
    end
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
